// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the master side.
package i2c_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
    ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_slave_if.sv
// Pad-side I2C signals; SDA is open drain, so the target only ever pulls it low.
interface i2c_slave_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave  (input scl_i, sda_i, output sda_oe);
  modport master (output scl_i, sda_i, input sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_ff, sda_ff;
  logic       scl_d, sda_d;
  logic       scl;

  // Reset to 1 so an idle bus does not look like an edge when rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_raw};
      sda_ff <= {sda_ff[0], sda_raw};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl      = scl_ff[1];
  assign sda      = sda_ff[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SCL must be high on both samples so an SDA change at an SCL edge is not misread.
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;
endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, 8-byte RX capture window, 8-byte TX read window.
module i2c_slave
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [6:0]        i_own_addr,
  input  logic [63:0]       i_tx_data,
  input  logic [2:0]        i_tx_len,
  i2c_slave_if.slave        bus,
  output logic [63:0]       o_rx_data,
  output logic [3:0]        o_rx_cnt,
  output logic              o_rx_done,
  output logic              o_tx_done,
  output logic              o_busy,
  output logic              o_err
);
  i2c_state_e  state;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic        rw;
  logic        wr_act;
  logic        sda_oe;
  logic        sda, scl_rise, scl_fall, start, stop;
  logic [7:0]  ld_byte;
  logic        end_pulse;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_raw  (bus.scl_i),
    .sda_raw  (bus.sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign bus.sda_oe = sda_oe;
  assign ld_byte    = i_tx_data[{byte_idx, 3'b000} +: 8];
  assign end_pulse  = wr_act && (o_rx_cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      rw        <= RW_WRITE;
      wr_act    <= 1'b0;
      sda_oe    <= 1'b0;
      o_rx_data <= '0;
      o_rx_cnt  <= '0;
      o_rx_done <= 1'b0;
      o_tx_done <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      o_tx_done <= 1'b0;
      if (!i_en) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
        wr_act <= 1'b0;
      end else if (stop) begin
        o_rx_done <= end_pulse;
        state     <= ST_IDLE;
        sda_oe    <= 1'b0;
        o_busy    <= 1'b0;
        wr_act    <= 1'b0;
      end else if (start) begin
        o_rx_done <= end_pulse;
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        o_busy    <= 1'b0;
        wr_act    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift[7:1] == i_own_addr) begin
                state    <= ST_ADDR_ACK;
                sda_oe   <= 1'b1;
                o_busy   <= 1'b1;
                o_err    <= 1'b0;
                rw       <= shift[0];
                byte_idx <= '0;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw == RW_WRITE) begin
                sda_oe    <= 1'b0;
                o_rx_data <= '0;
                o_rx_cnt  <= '0;
                wr_act    <= 1'b1;
                bit_cnt   <= '0;
                state     <= ST_WR_DATA;
              end else begin
                // First read bit goes out on the same fall that ends the address ACK.
                sda_oe  <= ~ld_byte[7];
                shift   <= {ld_byte[6:0], 1'b0};
                bit_cnt <= 4'd1;
                state   <= ST_RD_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (!o_rx_cnt[3]) begin
                o_rx_data[{o_rx_cnt[2:0], 3'b000} +: 8] <= shift;
                o_rx_cnt <= o_rx_cnt + 4'd1;
                sda_oe   <= 1'b1;
                state    <= ST_WR_ACK;
              end else begin
                o_err  <= 1'b1;
                sda_oe <= 1'b0;
                state  <= ST_WAIT_STOP;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ST_RD_ACK;
              end else if (bit_cnt == 4'd0) begin
                sda_oe  <= ~ld_byte[7];
                shift   <= {ld_byte[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda == ACK) begin
                // bit_cnt 0 makes the next fall load the following byte.
                bit_cnt <= '0;
                state   <= ST_RD_DATA;
                if (byte_idx == i_tx_len) begin
                  byte_idx <= '0;
                  o_err    <= 1'b1;
                end else begin
                  byte_idx <= byte_idx + 3'd1;
                end
              end else begin
                o_tx_done <= 1'b1;
                state     <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed I2C master bench with scoreboard queues for read bytes and rx_done events.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b1;
  logic [6:0]  own_addr = 7'h50;
  logic [63:0] tx_data = '0;
  logic [2:0]  tx_len = '0;
  logic [63:0] rx_data;
  logic [3:0]  rx_cnt;
  logic        rx_done, tx_done, busy, err;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;

  int total = 0;
  int bad = 0;
  int tx_seen = 0;
  int tx_exp = 0;
  logic [7:0] rd_q[$];
  logic [3:0] rx_q[$];

  i2c_slave_if bus ();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_slave dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_own_addr (own_addr),
    .i_tx_data  (tx_data),
    .i_tx_len   (tx_len),
    .bus        (bus),
    .o_rx_data  (rx_data),
    .o_rx_cnt   (rx_cnt),
    .o_rx_done  (rx_done),
    .o_tx_done  (tx_done),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b1; wait_q(2);
  endtask

  task automatic wbit(input logic b);
    m_sda = b;    wait_q(1);
    m_scl = 1'b1; wait_q(2);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    b = bus.sda_i; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
  endtask

  // Scoreboard side: every rx_done pulse must have been announced by the stimulus.
  always @(negedge clk) begin
    if (tx_done) tx_seen++;
    if (rx_done) begin
      chk("rx_done_expected", 64'(rx_q.size() != 0), 64'd1);
      if (rx_q.size() != 0) chk("rx_done_cnt", 64'(rx_cnt), 64'(rx_q.pop_front()));
    end
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] wr3 [3];
    wr3 = '{8'h11, 8'h22, 8'h33};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {58'b0, bus.sda_oe, rx_done, tx_done, busy, err, 1'b0}, 64'd0);
    chk("rst_rx_cnt", 64'(rx_cnt), 64'd0);
    chk("rst_rx_data", rx_data, 64'd0);
    rst = 1'b0;
    wait_q(2);

    // write three bytes
    bus_start();
    wbyte(8'hA0, ack);
    chk("w3_addr_ack", 64'(ack), 64'(ACK));
    chk("w3_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      wbyte(wr3[i], ack);
      chk("w3_data_ack", 64'(ack), 64'(ACK));
    end
    rx_q.push_back(4'd3);
    bus_stop();
    chk("w3_rx_data", 64'(rx_data[23:0]), 64'h332211);
    chk("w3_rx_cnt", 64'(rx_cnt), 64'd3);
    chk("w3_busy_end", 64'(busy), 64'd0);
    chk("w3_done_seen", 64'(rx_q.size()), 64'd0);

    // wrong address
    bus_start();
    wbyte(8'hA2, ack);
    chk("mis_nack", 64'(ack), 64'(NACK));
    chk("mis_busy", 64'(busy), 64'd0);
    bus_stop();
    chk("mis_rx_cnt", 64'(rx_cnt), 64'd3);
    chk("mis_tx_done", 64'(tx_seen), 64'(tx_exp));

    // read two bytes
    tx_data = 64'h0123_4567_89AB_A5C3;
    tx_len  = 3'd1;
    bus_start();
    wbyte(8'hA1, ack);
    chk("rd_addr_ack", 64'(ack), 64'(ACK));
    rd_q.push_back(8'hC3);
    rd_q.push_back(8'hA5);
    rbyte(d, ACK);
    chk("rd_byte0", 64'(d), 64'(rd_q.pop_front()));
    rbyte(d, NACK);
    chk("rd_byte1", 64'(d), 64'(rd_q.pop_front()));
    tx_exp++;
    wait_q(1);
    chk("rd_tx_done", 64'(tx_seen), 64'(tx_exp));
    chk("rd_err", 64'(err), 64'd0);
    bus_stop();

    // nine-byte overflow
    bus_start();
    wbyte(8'hA0, ack);
    chk("ovf_addr_ack", 64'(ack), 64'(ACK));
    for (int i = 0; i < 9; i++) begin
      wbyte(8'(i + 1), ack);
      chk("ovf_data_ack", 64'(ack), (i < 8) ? 64'(ACK) : 64'(NACK));
    end
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_rx_cnt", 64'(rx_cnt), 64'd8);
    chk("ovf_rx_data", rx_data, 64'h0807_0605_0403_0201);
    rx_q.push_back(4'd8);
    bus_stop();

    // write then repeated START into a read
    bus_start();
    wbyte(8'hA0, ack);
    wbyte(8'hAA, ack);
    chk("rs_wr_ack", 64'(ack), 64'(ACK));
    rx_q.push_back(4'd1);
    bus_start();
    chk("rs_done_seen", 64'(rx_q.size()), 64'd0);
    wbyte(8'hA1, ack);
    chk("rs_addr_ack", 64'(ack), 64'(ACK));
    chk("rs_err_clr", 64'(err), 64'd0);
    rd_q.push_back(8'hC3);
    rbyte(d, NACK);
    chk("rs_byte0", 64'(d), 64'(rd_q.pop_front()));
    tx_exp++;
    bus_stop();
    chk("rs_tx_done", 64'(tx_seen), 64'(tx_exp));
    chk("rs_rx_data", 64'(rx_data[7:0]), 64'hAA);

    // TX index wrap
    tx_len = 3'd0;
    bus_start();
    wbyte(8'hA1, ack);
    rd_q.push_back(8'hC3);
    rd_q.push_back(8'hC3);
    rbyte(d, ACK);
    chk("wrap_byte0", 64'(d), 64'(rd_q.pop_front()));
    rbyte(d, NACK);
    chk("wrap_byte1", 64'(d), 64'(rd_q.pop_front()));
    chk("wrap_err", 64'(err), 64'd1);
    tx_exp++;
    bus_stop();

    // reset while the slave drives the address ACK
    bus_start();
    a = 8'hA0;
    for (int i = 7; i >= 0; i--) wbit(a[i]);
    m_sda = 1'b1;
    wait_q(1);
    chk("rst_pre_oe", 64'(bus.sda_oe), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_oe", 64'(bus.sda_oe), 64'd0);
    chk("rst_mid_ctrl", {59'b0, rx_cnt, busy}, 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    chk("rst_mid_data", rx_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_scl = 1'b1;
    wait_q(2);
    bus_start();
    wbyte(8'hA0, ack);
    chk("post_rst_ack", 64'(ack), 64'(ACK));
    wbyte(8'h77, ack);
    rx_q.push_back(4'd1);
    bus_stop();
    chk("post_rst_data", rx_data, 64'h77);

    chk("end_rx_q", 64'(rx_q.size()), 64'd0);
    chk("end_rd_q", 64'(rd_q.size()), 64'd0);
    chk("end_tx_done", 64'(tx_seen), 64'(tx_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) controller, the responder end of the bus driven by the team's I2C master. Synchronises SCL/SDA to the system clock, detects START/STOP, matches a 7-bit own address, and ACKs the address. On master writes it captures up to 8 data bytes into a 64-bit RX window; on master reads it shifts out bytes from a 64-bit TX window. It sits behind the peripheral register block, mirroring the master's 64-bit data layout; the SDA open-drain tristate lives at the pad level.

## Interface
- No parameters; address width fixed at 7 bits, data windows fixed at 8 bytes.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  block enable; low forces IDLE and releases SDA
- i_own_addr  in  7  own slave address
- i_tx_data  in  64  read-response bytes; byte k = bits [8k+7:8k], byte 0 sent first
- i_tx_len  in  3  number of TX bytes minus 1 (0 → 1 byte, 7 → 8 bytes)
- scl_i  in  1  raw SCL pad input
- sda_i  in  1  raw SDA pad input
- sda_oe  out  1  1 = pull SDA low, 0 = release
- o_rx_data  out  64  write bytes; byte k at [8k+7:8k]
- o_rx_cnt  out  4  bytes received in the current/last write (0..8)
- o_rx_done  out  1  1-cycle pulse: write transaction ended (STOP or repeated START) with o_rx_cnt > 0
- o_tx_done  out  1  1-cycle pulse: master NACKed a read byte
- o_busy  out  1  addressed transaction in progress
- o_err  out  1  sticky: RX overflow (9th byte) or TX wrap; cleared by a new address match

## Operation
- Bus sync: two-flop synchronisers plus one delay register per line. SCL rise/fall = sync vs delayed value. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE → ADDR on START. ADDR shifts 8 bits MSB-first on SCL rise. Match on [7:1] == i_own_addr → ADDR_ACK; mismatch → WAIT_STOP, SDA never driven.
- ADDR_ACK: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall; o_busy=1; o_err cleared. R/W=0 → clear o_rx_data/o_rx_cnt, go WR_DATA. R/W=1 → byte index 0, go RD_DATA.
- WR_DATA: 8 bits on SCL rise. If o_rx_cnt < 8: store byte at index o_rx_cnt, increment, ACK in WR_ACK. Else: discard, set o_err, NACK (sda_oe=0), go WAIT_STOP.
- RD_DATA: drive SDA low when the current bit is 0, updating on each SCL fall. First bit is presented at the ADDR_ACK-ending fall. After 8 bits, release SDA → RD_ACK.
- RD_ACK: sample SDA on SCL rise. ACK → next index; past i_tx_len the index wraps to 0 and sets o_err. NACK → pulse o_tx_done, go WAIT_STOP.
- STOP in any state → IDLE, o_busy=0. START in any non-IDLE state (repeated START) → ADDR.
- Both STOP and repeated START pulse o_rx_done if the ending transaction was a write with o_rx_cnt > 0.
- i_tx_data and i_tx_len are sampled at each byte load; they must be stable during a read.

## Timing
- Reset values: sda_oe=0, o_rx_data=0, o_rx_cnt=0, o_rx_done=0, o_tx_done=0, o_busy=0, o_err=0, state IDLE, sync flops 1 (bus idle high).
- Requirement: clk ≥ 16 × SCL frequency; SCL high/low phases ≥ 4 clk.
- Pad-to-action latency is 3 clk: 2 sync stages plus 1 registered output. sda_oe changes 3 clk after the pad SCL fall.
- No clock stretching; SCL is never driven.
- START/STOP detection takes priority over a same-cycle SCL edge.
- Asynchronous rst mid-transfer releases SDA immediately and clears all outputs.
- i_en deassert: IDLE and sda_oe=0 on the next clk edge; no done pulses.

## Structure
- Shared package i2c_pkg: state enum, ACK=1'b0 / NACK=1'b1 constants, RW_WRITE/RW_READ. The master side reuses these.
- One sub-module, i2c_bus_sync: synchronisers, edge detect, START/STOP flags. Main FSM, shift register and byte counters stay in i2c_slave.

## Test plan
- Address 0x50, bench master writes 0x11,0x22,0x33 then STOP → three ACKs, o_rx_data[23:0]=0x332211, o_rx_cnt=3, one o_rx_done pulse.
- Bench addresses 0x51 while own address is 0x50 → no ACK (SDA stays high on 9th clock), o_busy stays 0, no pulses.
- Read, i_tx_data=0x..A5C3, i_tx_len=1, master ACKs byte 0 and NACKs byte 1 → bus shows 0xC3, 0xA5; o_tx_done pulses once; o_err=0.
- Write of 9 bytes → first 8 ACKed and stored, 9th NACKed, o_err=1, o_rx_cnt=8.
- Write 0xAA, repeated START, read 1 byte → o_rx_done pulses at the repeated START, then the read returns byte 0 of i_tx_data.
- Assert rst while slave drives an ACK → sda_oe=0 in the same cycle, all outputs at reset values, next START decoded normally.
